// File: rtl/pmem_pkg.sv
// rtl/pmem_pkg.sv - shared state type, default sizing and index-width helper for the pmem responder
package pmem_pkg;

  localparam int DEPTH_LOG2_DEFAULT = 8;
  localparam int LATENCY_DEFAULT    = 3;
  localparam int CNT_W              = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Width of a word index into a store of 2**depth_log2 words (at least one bit).
  function automatic int idx_width(input int depth_log2);
    return (depth_log2 < 1) ? 1 : depth_log2;
  endfunction

endpackage

// File: rtl/pmem_responder_if.sv
// rtl/pmem_responder_if.sv - pmem request/response bus between initiator and responder
interface pmem_responder_if;

  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/pmem_array.sv
// rtl/pmem_array.sv - word store with one synchronous write process and one combinational read port
module pmem_array
  import pmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                                clk,
  input  logic                                i_pmem_we,
  input  logic [idx_width(DEPTH_LOG2)-1:0]    i_pmem_idx,
  input  logic [31:0]                         i_pmem_data,
  input  logic                                i_init_we,
  input  logic [idx_width(DEPTH_LOG2)-1:0]    i_init_idx,
  input  logic [31:0]                         i_init_data,
  input  logic [idx_width(DEPTH_LOG2)-1:0]    i_rd_idx,
  output logic [31:0]                         o_rd_data
);

  logic [31:0] r_mem [2**DEPTH_LOG2];

  // Commit writes at end of cycle; the pmem write is ordered last so it wins an index collision
  always_ff @(posedge clk) begin
    if (i_init_we) begin
      r_mem[i_init_idx] <= i_init_data;
    end
    if (i_pmem_we) begin
      r_mem[i_pmem_idx] <= i_pmem_data;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle preload is not visible yet
  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency pmem responder with preload port and sticky protocol error flag
module pmem_responder
  import pmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
  parameter int LATENCY    = LATENCY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  pmem_responder_if.slave       pmem,
  input  logic                  init_we,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [31:0]           init_data,
  output logic                  proto_err
);

  localparam int IDX_W = idx_width(DEPTH_LOG2);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic               r_write;

  logic               w_req;
  logic               w_accept;
  logic               w_pmem_we;
  logic               w_init_we;
  logic [31:0]        w_rd_data;
  logic               w_addr_unused;

  assign w_req         = pmem.pmem_read | pmem.pmem_write;
  assign w_accept      = (r_state == ST_IDLE) && w_req;
  assign w_pmem_we     = (r_state == ST_RESP) && r_write;
  assign w_init_we     = init_we && !rst;
  assign w_addr_unused = ^{pmem.pmem_address[31:DEPTH_LOG2+2], pmem.pmem_address[1:0]};

  // State and latency counter register; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: RESP lands exactly LATENCY cycles after the accept cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (LATENCY <= 1) begin
            w_state_nxt = ST_RESP;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = LAT_M1;
          end
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_GAP;
      ST_GAP:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the request at accept and record protocol violations until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idx   <= pmem.pmem_address[DEPTH_LOG2+1:2];
        r_wdata <= pmem.pmem_wdata;
        r_write <= pmem.pmem_write;
        if (pmem.pmem_read && pmem.pmem_write) begin
          proto_err <= 1'b1;
        end
      end
      if ((r_state == ST_WAIT) && !w_req) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Response outputs are decoded from state; rdata is forced to zero outside a read response
  always_comb begin
    pmem.pmem_resp  = (r_state == ST_RESP);
    pmem.pmem_rdata = '0;
    if ((r_state == ST_RESP) && !r_write) begin
      pmem.pmem_rdata = w_rd_data;
    end
  end

  pmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk         (clk),
    .i_pmem_we   (w_pmem_we),
    .i_pmem_idx  (r_idx),
    .i_pmem_data (r_wdata),
    .i_init_we   (w_init_we),
    .i_init_idx  (init_addr),
    .i_init_data (init_data),
    .i_rd_idx    (r_idx),
    .o_rd_data   (w_rd_data)
  );

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - scoreboard bench for pmem_responder at LATENCY 3 and LATENCY 1
module tb_pmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_a, rst_b;
  logic        init_we_a, init_we_b;
  logic [7:0]  init_addr_a, init_addr_b;
  logic [31:0] init_data_a, init_data_b;
  logic        proto_err_a, proto_err_b;

  pmem_responder_if if_a ();
  pmem_responder_if if_b ();

  pmem_responder #(.DEPTH_LOG2(8), .LATENCY(3)) dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .pmem      (if_a),
    .init_we   (init_we_a),
    .init_addr (init_addr_a),
    .init_data (init_data_a),
    .proto_err (proto_err_a)
  );

  pmem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .pmem      (if_b),
    .init_we   (init_we_b),
    .init_addr (init_addr_b),
    .init_data (init_data_b),
    .proto_err (proto_err_b)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic mon_step(input bit sel, input logic resp, input logic [31:0] rdata);
    exp_t e;
    bit   empty;
    if (resp) begin
      checks++;
      empty = sel ? (q_b.size() == 0) : (q_a.size() == 0);
      if (empty) begin
        failures++;
        $display("FAIL resp_%0d unexpected pulse cyc=%0d rdata=%h expected=none", sel, cyc, rdata);
      end else begin
        if (sel) e = q_b.pop_front();
        else     e = q_a.pop_front();
        if (cyc != e.cyc || rdata !== e.data) begin
          failures++;
          $display("FAIL resp_%0d actual cyc=%0d rdata=%h expected cyc=%0d rdata=%h",
                   sel, cyc, rdata, e.cyc, e.data);
        end
      end
    end else begin
      checks++;
      if (rdata !== 32'h0) begin
        failures++;
        $display("FAIL idle_rdata_%0d cyc=%0d actual=%h expected=00000000", sel, cyc, rdata);
      end
    end
  endtask

  always @(negedge clk) if (mon_en) mon_step(1'b0, if_a.pmem_resp, if_a.pmem_rdata);
  always @(negedge clk) if (mon_en) mon_step(1'b1, if_b.pmem_resp, if_b.pmem_rdata);

  task automatic set_req(input bit sel, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (sel) begin
      if_b.pmem_read = rd; if_b.pmem_write = wr;
      if_b.pmem_address = addr; if_b.pmem_wdata = wdata;
    end else begin
      if_a.pmem_read = rd; if_a.pmem_write = wr;
      if_a.pmem_address = addr; if_a.pmem_wdata = wdata;
    end
  endtask

  task automatic set_init(input bit sel, input bit we, input logic [7:0] idx, input logic [31:0] data);
    if (sel) begin
      init_we_b = we; init_addr_b = idx; init_data_b = data;
    end else begin
      init_we_a = we; init_addr_a = idx; init_data_a = data;
    end
  endtask

  task automatic preload(input bit sel, input logic [7:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    set_init(sel, 1'b1, idx, data);
    @(posedge clk); #1;
    set_init(sel, 1'b0, 8'h0, 32'h0);
  endtask

  // Issue one request, push its expected response, hold until pmem_resp, then drop.
  // After accept the bus address/data are scrambled to show they are latched.
  task automatic req(input bit sel, input bit rd, input bit wr,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_data, input bit drop,
                     input bit coll, input logic [7:0] coll_idx, input logic [31:0] coll_data);
    int   lat;
    exp_t e;
    bit   got;
    lat = sel ? 1 : 3;
    @(posedge clk); #1;
    set_req(sel, rd, wr, addr, wdata);
    e.cyc  = cyc + lat;
    e.data = exp_data;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      set_req(sel, drop ? 1'b0 : rd, drop ? 1'b0 : wr, addr ^ 32'h0000_0FF4, ~wdata);
      if (coll && k == lat) set_init(sel, 1'b1, coll_idx, coll_data);
      else                  set_init(sel, 1'b0, 8'h0, 32'h0);
      got = sel ? if_b.pmem_resp : if_a.pmem_resp;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL req_timeout_%0d addr=%h actual=no_resp expected=resp", sel, addr);
    end
    @(posedge clk); #1;
    set_req(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    set_init(sel, 1'b0, 8'h0, 32'h0);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_init(1'b0, 1'b0, 8'h0, 32'h0);
    set_init(1'b1, 1'b0, 8'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("reset_resp_a",      32'(if_a.pmem_resp), 32'h0);
    chk("reset_rdata_a",     if_a.pmem_rdata,     32'h0);
    chk("reset_proto_err_a", 32'(proto_err_a),    32'h0);
    chk("reset_resp_b",      32'(if_b.pmem_resp), 32'h0);
    chk("reset_proto_err_b", 32'(proto_err_b),    32'h0);
    mon_en = 1'b1;

    preload(1'b0, 8'd4, 32'hDEADBEEF);
    preload(1'b0, 8'd2, 32'h0000_0001);
    preload(1'b1, 8'd3, 32'hCAFEF00D);
    preload(1'b1, 8'd5, 32'h0000_0005);

    // LATENCY 3: preloaded read, write then read with ignored byte offset
    req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 8'h0, 32'h0);
    req(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    req(1'b0, 1'b1, 1'b0, 32'h23, 32'h0, 32'h12345678, 1'b0, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    chk("proto_err_clean_a", 32'(proto_err_a), 32'h0);

    // Read and write together: executes as write and flags the error
    req(1'b0, 1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    chk("proto_err_both_a", 32'(proto_err_a), 32'h1);
    req(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    chk("proto_err_sticky_a", 32'(proto_err_a), 32'h1);

    // Reset during WAIT of a write: no response, store unchanged
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b1, 32'h8, 32'hFFFFFFFF);
    @(posedge clk); #1;
    rst_a = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    chk("proto_err_after_rst_a", 32'(proto_err_a), 32'h0);
    repeat (4) @(posedge clk);
    req(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 32'h0000_0001, 1'b0, 1'b0, 8'h0, 32'h0);

    // Request dropped during WAIT still completes and flags the error
    req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 8'h0, 32'h0);
    @(negedge clk);
    chk("proto_err_drop_a", 32'(proto_err_a), 32'h1);

    // Preload colliding with RESP write to the same index: pmem write wins
    req(1'b0, 1'b0, 1'b1, 32'h20, 32'h22, 32'h0, 1'b0, 1'b1, 8'd8, 32'h11);
    req(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h22, 1'b0, 1'b0, 8'h0, 32'h0);

    // Preload during a read RESP: old value returned, new value seen next time
    req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 8'd4, 32'h77);
    req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h77, 1'b0, 1'b0, 8'h0, 32'h0);

    // LATENCY 1: upper address bits ignored, write then read with offset bits set
    req(1'b1, 1'b1, 1'b0, 32'hFFFF_F00C, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 8'h0, 32'h0);
    req(1'b1, 1'b0, 1'b1, 32'h104, 32'h0BADC0DE, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    req(1'b1, 1'b1, 1'b0, 32'h106, 32'h0, 32'h0BADC0DE, 1'b0, 1'b0, 8'h0, 32'h0);

    // Preload strobe ignored while reset is held
    @(posedge clk); #1;
    rst_b = 1'b1;
    set_init(1'b1, 1'b1, 8'd5, 32'h55);
    @(posedge clk); #1;
    rst_b = 1'b0;
    set_init(1'b1, 1'b0, 8'h0, 32'h0);
    req(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 32'h0000_0005, 1'b0, 1'b0, 8'h0, 32'h0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_empty_a", 32'(q_a.size()), 32'h0);
    chk("queue_empty_b", 32'(q_b.size()), 32'h0);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
